rng_collector: RTL
==================

# rng_collector

Consumer end of the single-bit `rng` stream. It samples raw random bits, removes bias with an optional von Neumann corrector, and packs the accepted bits into WIDTH-bit words. Words are delivered on a valid/ready handshake. It also runs a repetition-count health test that latches a sticky error and stops word production when the source appears stuck.

## Interface
- `WIDTH`, default 8: output word width. Legal range 2..32.
- `DEBIAS`, default 1: 1 enables von Neumann pairing; 0 passes every sampled bit through.
- `REP_LIMIT`, default 16: run length of identical raw samples that trips `stuck_err`. Must be ≥2.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  raw bit from `rng.bit_out`.
- `bit_en`  in  1  sample `bit_in` on this edge; when low, no state advances.
- `word_out`  out  WIDTH  assembled random word.
- `word_valid`  out  1  `word_out` holds an undelivered word.
- `word_ready`  in  1  downstream accepts `word_out` on an edge where `word_valid` is high.
- `stuck_err`  out  1  sticky health-test failure.

## Operation
- **Reset (async, immediate):**
  - Outputs: `word_out`=0, `word_valid`=0, `stuck_err`=0.
  - Internal: accumulator `acc`=0, count `cnt`=0, pair phase=0, first-bit latch=0, run counter=0, last-bit=0.
- **Pair stage (DEBIAS=1), per `bit_en` sample:**
  - Phase 0: latch the bit, go to phase 1.
  - Phase 1: if the sample differs from the latch, emit the latched bit (pair 10→1, 01→0). Pairs 00 and 11 emit nothing. Return to phase 0.
- **DEBIAS=0:** every sample is emitted; phase is unused.
- **Accumulator:**
  - An emitted bit updates `acc <= {acc[WIDTH-2:0], bit}` and `cnt++`. The first accepted bit ends up in the word's MSB.
  - When `cnt==WIDTH`, `acc` is full. While full, emitted bits are dropped, but the pair phase still advances.
- **Word transfer.** The output register is *free* when `!word_valid || word_ready`. On an edge where it is free:
  - If `cnt==WIDTH`: `word_out<=acc`, `word_valid<=1`, `cnt<=0`. A bit emitted on the same edge becomes bit 1 of the next word (`cnt<=1`).
  - Else if an emitted bit completes the word (`cnt==WIDTH-1`): load the completed word directly into `word_out`, set `word_valid<=1`, `cnt<=0`.
  - Else, if `word_valid && word_ready`: `word_valid<=0`.
- **Handshake:**
  - `word_out` is stable while `word_valid && !word_ready`.
  - A transfer happens on any edge with `word_valid && word_ready`.
  - Back-to-back words are legal.
- **Health test:**
  - Runs on raw samples, independent of DEBIAS.
  - If a sample equals last-bit, the run counter increments (saturating at REP_LIMIT); otherwise it resets to 1. The first sample after reset counts as run 1.
  - When the run reaches REP_LIMIT, set `stuck_err<=1`. It stays set until reset.
  - While `stuck_err`=1: samples are ignored, `acc`/`cnt`/phase are frozen, and no new word is loaded. A word already in `word_out` still drains normally.

## Timing
- Latency (DEBIAS=1, output free): `word_valid` rises on the edge that samples the second bit of the WIDTH-th differing pair.
- DEBIAS=0: `word_valid` rises on the edge that samples the WIDTH-th bit.
- Full accumulator under backpressure: the next word appears on the edge that accepts the previous one, so `word_valid` stays high.
- `stuck_err` asserts on the edge sampling the REP_LIMIT-th identical bit.
- Reset mid-word discards the partial word and any pending output. After release, a full fresh word is required.

## Test plan
- **Basic packing.** DEBIAS=1, WIDTH=8, `word_ready`=1, `bit_en`=1; stream 1,0,0,1,1,0,1,0,0,1,0,1,1,0,0,1 → `word_out`=8'hB2 with `word_valid` high for one cycle after the 16th sample. `stuck_err` stays 0.
- **Discards.** Same stream with pairs 0,0 and 1,1 inserted between every pair → same 8'hB2; `cnt` unchanged by the inserted pairs.
- **Backpressure.**
  - `word_ready`=0; feed three words' worth of pairs → first word held stable, second stays in `acc`, third word's bits are dropped.
  - Raise `word_ready` for 2 cycles → first word accepted, second word shown on that edge, then accepted; `word_valid` then drops.
- **Stuck source.** `bit_in`=1 for 16 `bit_en` cycles → `stuck_err`=1 after the 16th edge. Further alternating input produces no words. Assert `rst_n`=0 → `stuck_err`=0.
- **Toggling source.** Input 0,1,0,1… (the `rng` toggle pattern) → 8'h00 every 16 enabled cycles; no `stuck_err`.
- **Reset mid-word.** Pull `rst_n` low after 5 valid pairs → all outputs 0 immediately. After release, 8 new pairs are required before `word_valid` rises.

Source files
------------

// File: rtl/rng_collector.sv
// rng_collector
// Consumer end of a single-bit random stream. Raw samples optionally pass
// through a von Neumann corrector, accepted bits are packed MSB-first into
// WIDTH-bit words, and words leave on a valid/ready handshake. A
// repetition-count health test latches a sticky error and halts word
// production when the source looks stuck.

module rng_collector #(
   parameter int WIDTH     = 8,
   parameter int DEBIAS    = 1,
   parameter int REP_LIMIT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_en,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             stuck_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int RUN_W = $clog2(REP_LIMIT + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

   // Pair phase of the von Neumann corrector.
   typedef enum logic {
      PH_FIRST  = 1'b0,
      PH_SECOND = 1'b1
   } phase_t;

   // Registered state
   logic [WIDTH-1:0] acc_reg,   acc_next;
   logic [CNT_W-1:0] cnt_reg,   cnt_next;
   phase_t           phase_reg, phase_next;
   logic             first_reg, first_next;
   logic [RUN_W-1:0] run_reg,   run_next;
   logic             last_reg,  last_next;
   logic [WIDTH-1:0] word_reg,  word_next;
   logic             valid_reg, valid_next;
   logic             stuck_reg, stuck_next;

   // Combinational helpers
   logic             sample;
   logic             emit;
   logic             emit_bit;
   logic             out_free;
   logic             acc_full;
   logic [WIDTH-1:0] acc_shifted;

   // A sample is only honoured while the health test has not tripped.
   assign sample      = bit_en & ~stuck_reg;
   assign out_free    = ~valid_reg | word_ready;
   assign acc_full    = (cnt_reg == CNT_FULL);
   assign acc_shifted = {acc_reg[WIDTH-2:0], emit_bit};

   // Pair stage: decides whether this sample yields an accepted bit.
   always_comb begin
      emit       = 1'b0;
      emit_bit   = bit_in;
      phase_next = phase_reg;
      first_next = first_reg;
      if (DEBIAS != 0) begin
         if (sample) begin
            if (phase_reg == PH_FIRST) begin
               first_next = bit_in;
               phase_next = PH_SECOND;
            end else begin
               phase_next = PH_FIRST;
               // 10 -> 1, 01 -> 0; equal pairs carry no entropy.
               if (bit_in != first_reg) begin
                  emit     = 1'b1;
                  emit_bit = first_reg;
               end
            end
         end
      end else begin
         emit = sample;
      end
   end

   // Repetition-count health test on raw samples.
   always_comb begin
      run_next   = run_reg;
      last_next  = last_reg;
      stuck_next = stuck_reg;
      if (sample) begin
         last_next = bit_in;
         // run_reg==0 only before the first sample after reset.
         if ((run_reg != '0) && (bit_in == last_reg)) begin
            if (run_reg != RUN_MAX) begin
               run_next = run_reg + RUN_ONE;
            end
         end else begin
            run_next = RUN_ONE;
         end
         if (run_next == RUN_MAX) begin
            stuck_next = 1'b1;
         end
      end
   end

   // Accumulator and output register with valid/ready transfer.
   always_comb begin
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      word_next  = word_reg;
      valid_next = valid_reg;
      if (!stuck_reg && out_free && acc_full) begin
         // Full accumulator moves out; a bit emitted now starts the next word.
         word_next  = acc_reg;
         valid_next = 1'b1;
         if (emit) begin
            acc_next = acc_shifted;
            cnt_next = CNT_ONE;
         end else begin
            cnt_next = '0;
         end
      end else if (!stuck_reg && out_free && emit && (cnt_reg == CNT_LAST)) begin
         // Completing bit goes straight to the output, saving a cycle.
         word_next  = acc_shifted;
         valid_next = 1'b1;
         cnt_next   = '0;
      end else begin
         // Bits emitted while full are dropped.
         if (emit && !acc_full) begin
            acc_next = acc_shifted;
            cnt_next = cnt_reg + CNT_ONE;
         end
         if (valid_reg && word_ready) begin
            valid_next = 1'b0;
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg   <= '0;
         cnt_reg   <= '0;
         phase_reg <= PH_FIRST;
         first_reg <= 1'b0;
         run_reg   <= '0;
         last_reg  <= 1'b0;
         word_reg  <= '0;
         valid_reg <= 1'b0;
         stuck_reg <= 1'b0;
      end else begin
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         phase_reg <= phase_next;
         first_reg <= first_next;
         run_reg   <= run_next;
         last_reg  <= last_next;
         word_reg  <= word_next;
         valid_reg <= valid_next;
         stuck_reg <= stuck_next;
      end
   end

   assign word_out   = word_reg;
   assign word_valid = valid_reg;
   assign stuck_err  = stuck_reg;

endmodule
